// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Drives the 4-digit 7-segment display from the two dmem-mapped operands.
// Every REFRESH_DIV cycles the operands are sampled and added. A small
// double-dabble FSM converts the IN_W+1-bit sum to three BCD digits. The
// digits are then time-multiplexed onto one shared BCD bus.
//
// Ports
//   clk       : system clock, all state on posedge
//   reset     : asynchronous, active-high
//   entrada1  : operand A (IN_W bits)
//   entrada2  : operand B (IN_W bits)
//   digitos   : one-hot digit enable, active-high (registered)
//   dis       : BCD value for the enabled digit, 4'hF = blank (registered)
//   busy      : high while a conversion is in progress
//   sum_q     : last latched sum (debug)
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 13_500_000,
    parameter int unsigned SCAN_DIV    = 2048,
    parameter int unsigned IN_W        = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IN_W-1:0] entrada1,
    input  logic [IN_W-1:0] entrada2,
    output logic [3:0]      digitos,
    output logic [3:0]      dis,
    output logic            busy,
    output logic [IN_W:0]   sum_q
);

    localparam int unsigned SumW  = IN_W + 1;
    localparam int unsigned BcdW  = 12;
    localparam int unsigned ShW   = BcdW + SumW;
    localparam int unsigned PreW  = $clog2(REFRESH_DIV);
    localparam int unsigned ScanW = $clog2(SCAN_DIV);
    localparam int unsigned IterW = $clog2(SumW + 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_e state_q, state_d;

    logic [PreW-1:0]  presc_q, presc_d;
    logic             tick;

    logic [SumW-1:0]  sum_d;
    logic [SumW-1:0]  sum_next;
    logic [ShW-1:0]   shreg_q, shreg_d;
    logic [ShW-1:0]   shreg_adj;
    logic [IterW-1:0] iter_q, iter_d;

    logic             load_en;
    logic             shift_en;
    logic             commit_en;

    logic [3:0]       h_q, h_d;
    logic [3:0]       t_q, t_d;
    logic [3:0]       u_q, u_d;

    logic [ScanW-1:0] scan_q, scan_d;
    logic             scan_wrap;
    logic [1:0]       idx_q, idx_d;

    logic [3:0]       digitos_q, digitos_d;
    logic [3:0]       dis_q, dis_d;

    // ------------------------------------------------------------------------
    // Refresh prescaler: tick is high for exactly the terminal-count cycle
    // ------------------------------------------------------------------------
    always_comb begin
        tick    = (presc_q == PreW'(REFRESH_DIV - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // ------------------------------------------------------------------------
    // Conversion FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Conversion FSM: next state
    // A tick arriving outside StIdle is simply ignored.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                // This cycle performs the last of the SumW shifts.
                if (iter_q == IterW'(SumW - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Conversion FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != StIdle);
        load_en   = (state_q == StIdle) && tick;
        shift_en  = (state_q == StShift);
        commit_en = (state_q == StCommit);
    end

    // ------------------------------------------------------------------------
    // Double-dabble datapath
    // Shift register layout: {hundreds, tens, units, binary sum}.
    // ------------------------------------------------------------------------
    always_comb begin
        // Operands are zero-extended so the sum can never overflow.
        sum_next = SumW'(entrada1) + SumW'(entrada2);

        // Add 3 to every BCD nibble >= 5 before the shift.
        shreg_adj = shreg_q;
        for (int i = 0; i < 3; i++) begin
            if (shreg_q[SumW + 4*i +: 4] >= 4'd5) begin
                shreg_adj[SumW + 4*i +: 4] = shreg_q[SumW + 4*i +: 4] + 4'd3;
            end
        end

        sum_d   = sum_q;
        shreg_d = shreg_q;
        iter_d  = iter_q;

        if (load_en) begin
            sum_d   = sum_next;
            shreg_d = {{BcdW{1'b0}}, sum_next};
            iter_d  = '0;
        end else if (shift_en) begin
            shreg_d = ShW'({shreg_adj, 1'b0});
            iter_d  = iter_q + 1'b1;
        end
    end

    // All three display digits update on the same edge so the scan never
    // shows a mix of old and new digits.
    always_comb begin
        h_d = h_q;
        t_d = t_q;
        u_d = u_q;
        if (commit_en) begin
            h_d = shreg_q[SumW + 8 +: 4];
            t_d = shreg_q[SumW + 4 +: 4];
            u_d = shreg_q[SumW     +: 4];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            sum_q   <= '0;
            shreg_q <= '0;
            iter_q  <= '0;
            h_q     <= '0;
            t_q     <= '0;
            u_q     <= '0;
        end else begin
            presc_q <= presc_d;
            sum_q   <= sum_d;
            shreg_q <= shreg_d;
            iter_q  <= iter_d;
            h_q     <= h_d;
            t_q     <= t_d;
            u_q     <= u_d;
        end
    end

    // ------------------------------------------------------------------------
    // Digit scan (free-running, independent of the FSM)
    // ------------------------------------------------------------------------
    always_comb begin
        scan_wrap = (scan_q == ScanW'(SCAN_DIV - 1));
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        // Two-bit index wraps 3 -> 0 naturally.
        idx_d     = scan_wrap ? idx_q + 2'd1 : idx_q;
    end

    // Outputs are registered from next-state values: digitos and dis move on
    // the same edge as the index, and a committed value reaches dis on the
    // edge right after the commit.
    always_comb begin
        digitos_d = 4'b0001 << idx_d;
        case (idx_d)
            2'd0: dis_d = u_d;
            2'd1: dis_d = (h_d == 4'd0 && t_d == 4'd0) ? 4'hF : t_d;
            2'd2: dis_d = (h_d == 4'd0) ? 4'hF : h_d;
            default: dis_d = 4'hF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_q    <= '0;
            idx_q     <= '0;
            digitos_q <= 4'b0001;
            dis_q     <= 4'h0;
        end else begin
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            digitos_q <= digitos_d;
            dis_q     <= dis_d;
        end
    end

    assign digitos = digitos_q;
    assign dis     = dis_q;

endmodule
